// File: rtl/mips_pkg.sv
// Shared types for the instruction fetch path: machine word width, the NOP
// encoding and the entry format carried through the instruction queue.
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
        logic            err;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/instr_fetch_resp_if.sv
// Request, instruction-memory and decode-side signals of the fetch response block.
// The fetch block itself is the slave; the core/memory side is the master.
interface instr_fetch_resp_if
    import mips_pkg::*;
#(
    parameter int AW = 8
) ();

    logic            req_valid;
    logic [XLEN-1:0] req_pc;
    logic            req_ready;
    logic            flush;
    logic            imem_en;
    logic [AW-1:0]   imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_err;
    logic            inst_ready;
    logic [XLEN-1:0] fetch_cnt;

    modport slave (
        input  req_valid, req_pc, flush, imem_rdata, inst_ready,
        output req_ready, imem_en, imem_addr, inst_valid, inst_data, inst_pc, inst_err, fetch_cnt
    );

    modport master (
        output req_valid, req_pc, flush, imem_rdata, inst_ready,
        input  req_ready, imem_en, imem_addr, inst_valid, inst_data, inst_pc, inst_err, fetch_cnt
    );

endinterface

// File: rtl/fetch_fifo.sv
// First-word-fall-through queue: rdata always shows the oldest entry.
// clear beats push and pop; push when full and pop when empty are ignored.
module fetch_fifo #(
    parameter int QDEPTH = 4,
    parameter int WIDTH  = 65
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(QDEPTH);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignment so each one samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which words are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction fetch response path: issues synchronous imem reads, tracks one
// in-flight fetch and queues the returned words for decode in request order.
module instr_fetch_resp
    import mips_pkg::*;
#(
    parameter int AW     = 8,
    parameter int QDEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    instr_fetch_resp_if.slave bus
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(QDEPTH);

    logic            rst_meta_q, rst_n_q;
    logic            inflight_valid_q, inflight_valid_d;
    logic            inflight_err_q, inflight_err_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     reserved;
    logic            fifo_full, fifo_empty;
    logic            push, pop, accept, legal, req_ready;
    fetch_entry_t    push_entry, head_entry;
    logic [ENTRY_W-1:0] head_raw;

    // Reset asserts immediately but releases two edges later, keeping req_ready low until then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    always_comb begin
        // A slot is reserved for the in-flight fetch so a push can never find the queue full.
        reserved  = {1'b0, fifo_count} + (CW+1)'(inflight_valid_q);
        req_ready = rst_n_q && !bus.flush && !fifo_full && (reserved < DEPTH_L);
        accept    = bus.req_valid && req_ready;
        legal     = (bus.req_pc[1:0] == 2'b00) && ((bus.req_pc >> (AW + 2)) == '0);

        // flush forces req_ready low, which also clears the in-flight slot.
        inflight_valid_d = accept;
        inflight_pc_d    = bus.req_pc;
        inflight_err_d   = !legal;

        push = inflight_valid_q;
        if (inflight_err_q) push_entry = '{data: NOP_INSTR, pc: inflight_pc_q, err: 1'b1};
        else                push_entry = '{data: bus.imem_rdata, pc: inflight_pc_q, err: 1'b0};

        pop         = !fifo_empty && bus.inst_ready;
        fetch_cnt_d = fetch_cnt_q + XLEN'(pop);
        head_entry  = fifo_empty ? '0 : fetch_entry_t'(head_raw);
    end

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            inflight_valid_q <= 1'b0;
            inflight_err_q   <= 1'b0;
            inflight_pc_q    <= '0;
            fetch_cnt_q      <= '0;
        end else begin
            inflight_valid_q <= inflight_valid_d;
            inflight_err_q   <= inflight_err_d;
            inflight_pc_q    <= inflight_pc_d;
            fetch_cnt_q      <= fetch_cnt_d;
        end
    end

    fetch_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n_q),
        .push  (push),
        .pop   (pop),
        .clear (bus.flush),
        .wdata (push_entry),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.req_ready  = req_ready;
    assign bus.imem_en    = accept && legal;
    assign bus.imem_addr  = bus.req_pc[AW+1:2];
    assign bus.inst_valid = !fifo_empty;
    assign bus.inst_data  = head_entry.data;
    assign bus.inst_pc    = head_entry.pc;
    assign bus.inst_err   = head_entry.err;
    assign bus.fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_resp.sv
// Directed bench for instr_fetch_resp: inputs change and outputs are sampled
// just after the falling edge; a behavioural synchronous RAM returns 0x1000_0000 + word address.
module tb_instr_fetch_resp;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    int          acc, stall_en, popped;
    logic [31:0] pc_next, exp_pc;

    always #5 clk = ~clk;

    instr_fetch_resp_if #(.AW(8)) bus ();

    instr_fetch_resp #(
        .AW     (8),
        .QDEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk)
        bus.imem_rdata <= bus.imem_en ? 32'h1000_0000 + {24'h0, bus.imem_addr} : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] pc, input logic fl, input logic ir);
        @(negedge clk);
        bus.req_valid  = rv;
        bus.req_pc     = pc;
        bus.flush      = fl;
        bus.inst_ready = ir;
        #1;
    endtask

    task automatic expect_head(input string tag, input logic v, input logic [31:0] d,
                               input logic [31:0] pc, input logic e);
        check({tag, "_valid"}, bus.inst_valid, v);
        check({tag, "_data"},  bus.inst_data,  d);
        check({tag, "_pc"},    bus.inst_pc,    pc);
        check({tag, "_err"},   bus.inst_err,   e);
    endtask

    task automatic expect_all_zero(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_imem_en"},   bus.imem_en,   0);
        check({tag, "_fetch_cnt"}, bus.fetch_cnt, 0);
        expect_head(tag, 0, 0, 0, 0);
    endtask

    task automatic release_reset(input string tag);
        bus.req_valid  = 1'b0;
        bus.inst_ready = 1'b0;
        bus.flush      = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        check({tag, "_rr_edge1"}, bus.req_ready, 0);
        @(negedge clk); #1;
        check({tag, "_rr_edge2"}, bus.req_ready, 1);
    endtask

    // Watches a streaming head and compares it with the bench's running pc.
    task automatic check_pop(input string tag);
        if (bus.inst_valid) begin
            check({tag, "_pc"},   bus.inst_pc,   exp_pc);
            check({tag, "_data"}, bus.inst_data, 32'h1000_0000 + ((exp_pc >> 2) & 32'hFF));
            exp_pc += 4;
            popped++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_pc     = 32'h0;
        bus.flush      = 1'b0;
        bus.inst_ready = 1'b1;
        #12;
        expect_all_zero("rst");
        release_reset("rst");

        // Back-to-back requests, head appears two cycles after the first accept.
        drive(1, 32'h0, 0, 1);
        check("b2b_c0_en", bus.imem_en, 1);
        check("b2b_c0_addr", bus.imem_addr, 0);
        check("b2b_c0_valid", bus.inst_valid, 0);
        drive(1, 32'h4, 0, 1);
        check("b2b_c1_addr", bus.imem_addr, 1);
        check("b2b_c1_valid", bus.inst_valid, 0);
        drive(1, 32'h8, 0, 1);
        check("b2b_c2_addr", bus.imem_addr, 2);
        expect_head("b2b_c2", 1, 32'h1000_0000, 32'h0, 0);
        drive(0, 32'h0, 0, 1);
        expect_head("b2b_c3", 1, 32'h1000_0001, 32'h4, 0);
        drive(0, 32'h0, 0, 1);
        expect_head("b2b_c4", 1, 32'h1000_0002, 32'h8, 0);
        drive(0, 32'h0, 0, 1);
        expect_head("b2b_c5", 0, 0, 0, 0);
        check("b2b_cnt", bus.fetch_cnt, 3);

        // Stalled decode: only QDEPTH requests fit, then drain in order.
        acc = 0; stall_en = 0; pc_next = 32'h10;
        for (int i = 0; i < 10; i++) begin
            drive(1, pc_next, 0, 0);
            if (bus.req_ready) begin
                acc++;
                pc_next += 4;
            end else if (bus.imem_en) begin
                stall_en++;
            end
        end
        check("stall_accepted", acc, 4);
        check("stall_imem_en", stall_en, 0);
        check("stall_rr", bus.req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 32'h0, 0, 1);
            expect_head($sformatf("drain%0d", k), 1, 32'h1000_0004 + k, 32'h10 + 4 * k, 0);
        end
        drive(0, 32'h0, 0, 1);
        check("drain_empty", bus.inst_valid, 0);
        check("drain_cnt", bus.fetch_cnt, 7);

        // Misaligned and out-of-range addresses become fault entries without a read.
        drive(1, 32'h6, 0, 0);
        check("bad_rr0", bus.req_ready, 1);
        check("bad_en0", bus.imem_en, 0);
        drive(1, 32'h400, 0, 0);
        check("bad_en1", bus.imem_en, 0);
        drive(0, 32'h0, 0, 1);
        expect_head("bad_h0", 1, 32'h0, 32'h6, 1);
        drive(0, 32'h0, 0, 1);
        expect_head("bad_h1", 1, 32'h0, 32'h400, 1);
        drive(0, 32'h0, 0, 1);
        check("bad_empty", bus.inst_valid, 0);
        check("bad_cnt", bus.fetch_cnt, 9);

        // Flush with three queued and one in flight; the pop in the flush cycle still counts.
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h20 + 4 * k, 0, 0);
            check($sformatf("fl_rr%0d", k), bus.req_ready, 1);
        end
        drive(1, 32'h80, 1, 1);
        check("fl_rr", bus.req_ready, 0);
        check("fl_en", bus.imem_en, 0);
        check("fl_head_pc", bus.inst_pc, 32'h20);
        drive(0, 32'h0, 0, 0);
        check("fl_after_valid", bus.inst_valid, 0);
        check("fl_after_cnt", bus.fetch_cnt, 10);
        drive(1, 32'h40, 0, 1);
        check("fl_new_en", bus.imem_en, 1);
        drive(0, 32'h0, 0, 1);
        check("fl_new_c1", bus.inst_valid, 0);
        drive(0, 32'h0, 0, 1);
        expect_head("fl_new", 1, 32'h1000_0010, 32'h40, 0);
        drive(0, 32'h0, 0, 1);
        check("fl_sole", bus.inst_valid, 0);
        check("fl_cnt", bus.fetch_cnt, 11);

        // Fill, then stream with push and pop every cycle: order and count preserved.
        acc = 0; popped = 0; pc_next = 32'h100; exp_pc = 32'h100;
        for (int i = 0; i < 6; i++) begin
            drive(1, pc_next, 0, 0);
            if (bus.req_ready) begin
                acc++;
                pc_next += 4;
            end
        end
        check("strm_fill", acc, 4);
        for (int i = 0; i < 20; i++) begin
            drive(1, pc_next, 0, 1);
            check_pop($sformatf("strm%0d", i));
            if (bus.req_ready) begin
                acc++;
                pc_next += 4;
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 32'h0, 0, 1);
            check_pop($sformatf("strm_drain%0d", i));
        end
        check("strm_empty", bus.inst_valid, 0);
        check("strm_no_loss", popped, acc);
        check("strm_cnt", bus.fetch_cnt, 11 + popped);

        // Asynchronous reset in the middle of a cycle with a full queue.
        pc_next = 32'h200;
        for (int i = 0; i < 6; i++) begin
            drive(1, pc_next, 0, 0);
            if (bus.req_ready) pc_next += 4;
        end
        check("arst_full_rr", bus.req_ready, 0);
        check("arst_full_valid", bus.inst_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        expect_all_zero("arst");
        release_reset("arst");
        check("arst_cnt", bus.fetch_cnt, 0);
        check("arst_valid", bus.inst_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
